// File: rtl/voice_mixer_pkg.sv
// rtl/voice_mixer_pkg.sv - shared constants, state encoding and helpers for the voice mixer
package voice_mixer_pkg;

  localparam int BITDEPTH_DEFAULT = 14;
  localparam int VOLBITS          = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_SCALE = 2'd2,
    ST_OUT   = 2'd3
  } mix_state_t;

  // Offset-binary code for silence at a given sample width
  function automatic int midscale(input int bitdepth);
    return 1 << (bitdepth - 1);
  endfunction

endpackage

// File: rtl/voice_mixer_mix_saturate.sv
// rtl/voice_mixer_mix_saturate.sv - clamps a wide signed sample and converts it to offset-binary
module mix_saturate
  import voice_mixer_pkg::*;
#(
  parameter int IN_W     = 26,
  parameter int BITDEPTH = BITDEPTH_DEFAULT
) (
  input  logic signed [IN_W-1:0]     i_value,
  output logic        [BITDEPTH-1:0] o_pcm
);

  localparam logic signed [IN_W-1:0] MAX_S = IN_W'(midscale(BITDEPTH) - 1);
  localparam logic signed [IN_W-1:0] MIN_S = IN_W'(-midscale(BITDEPTH));

  logic signed [IN_W-1:0] w_clamped;
  logic                   w_unused_hi;

  always_comb begin
    w_clamped = i_value;
    if (i_value > MAX_S) begin
      w_clamped = MAX_S;
    end else if (i_value < MIN_S) begin
      w_clamped = MIN_S;
    end
  end

  // Adding midscale to a two's-complement value in range is just an MSB flip
  assign o_pcm       = {~w_clamped[BITDEPTH-1], w_clamped[BITDEPTH-2:0]};
  assign w_unused_hi = ^w_clamped[IN_W-1:BITDEPTH];

endmodule

// File: rtl/voice_mixer.sv
// rtl/voice_mixer.sv - time-multiplexed voice summer with master volume and saturation
module voice_mixer
  import voice_mixer_pkg::*;
#(
  parameter int BITDEPTH       = BITDEPTH_DEFAULT,
  parameter int NVOICES        = 4,
  parameter int HEADROOM_SHIFT = 2
) (
  input  logic                        i_clk,
  input  logic                        i_resetn,
  input  logic                        i_sample_clock,
  input  logic [NVOICES*BITDEPTH-1:0] i_voices_in,
  input  logic [NVOICES-1:0]          i_voice_enable,
  input  logic [VOLBITS-1:0]          i_master_volume,
  output logic [BITDEPTH-1:0]         o_mix,
  output logic                        o_mix_valid,
  output logic                        o_busy,
  output logic                        o_overrun
);

  localparam int ACC_W  = BITDEPTH + $clog2(NVOICES) + 1;
  localparam int PROD_W = ACC_W + VOLBITS + 1;
  localparam int IDX_W  = (NVOICES > 1) ? $clog2(NVOICES) : 1;
  localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(NVOICES - 1);
  localparam logic signed [ACC_W-1:0] MID_ACC  = ACC_W'(midscale(BITDEPTH));
  localparam logic [BITDEPTH-1:0]     MID_PCM  = BITDEPTH'(midscale(BITDEPTH));

  mix_state_t                  r_state, w_state_nxt;
  logic                        r_sc_q, r_rise;
  logic [NVOICES*BITDEPTH-1:0] r_voices;
  logic [NVOICES-1:0]          r_en;
  logic [VOLBITS-1:0]          r_vol;
  logic [IDX_W-1:0]            r_idx;
  logic signed [ACC_W-1:0]     r_acc;
  logic signed [PROD_W-1:0]    r_prod;
  logic [BITDEPTH-1:0]         r_mix;
  logic                        r_mix_valid, r_busy, r_overrun;

  logic                        w_snap, w_accum, w_scale, w_out;
  logic [BITDEPTH-1:0]         w_voice, w_mix_sat;
  logic signed [ACC_W-1:0]     w_term;
  logic signed [PROD_W-1:0]    w_shifted;

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (r_rise) w_state_nxt = ST_ACCUM;
      ST_ACCUM: if (r_idx == LAST_IDX) w_state_nxt = ST_SCALE;
      ST_SCALE: w_state_nxt = ST_OUT;
      ST_OUT:   w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_snap  = (r_state == ST_IDLE) && r_rise;
    w_accum = (r_state == ST_ACCUM);
    w_scale = (r_state == ST_SCALE);
    w_out   = (r_state == ST_OUT);
  end

  assign w_voice   = r_voices[r_idx*BITDEPTH +: BITDEPTH];
  assign w_term    = $signed({{(ACC_W-BITDEPTH){1'b0}}, w_voice}) - MID_ACC;
  assign w_shifted = r_prod >>> (VOLBITS + HEADROOM_SHIFT);

  mix_saturate #(
    .IN_W     (PROD_W),
    .BITDEPTH (BITDEPTH)
  ) u_sat (
    .i_value (w_shifted),
    .o_pcm   (w_mix_sat)
  );

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_sc_q      <= 1'b0;
      r_rise      <= 1'b0;
      r_voices    <= '0;
      r_en        <= '0;
      r_vol       <= '0;
      r_idx       <= '0;
      r_acc       <= '0;
      r_prod      <= '0;
      r_mix       <= MID_PCM;
      r_mix_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      // Rise is registered so each sample_clock edge becomes a clean one-clk request
      r_sc_q      <= i_sample_clock;
      r_rise      <= i_sample_clock & ~r_sc_q;
      r_mix_valid <= 1'b0;
      if (r_rise && (r_state != ST_IDLE)) begin
        r_overrun <= 1'b1;
      end
      if (w_snap) begin
        r_voices <= i_voices_in;
        r_en     <= i_voice_enable;
        r_vol    <= i_master_volume;
        r_acc    <= '0;
        r_idx    <= '0;
        r_busy   <= 1'b1;
      end
      if (w_accum) begin
        if (r_en[r_idx]) begin
          r_acc <= r_acc + w_term;
        end
        r_idx <= r_idx + 1'b1;
      end
      if (w_scale) begin
        r_prod <= PROD_W'(r_acc) * PROD_W'($signed({1'b0, r_vol}));
      end
      if (w_out) begin
        r_mix       <= w_mix_sat;
        r_mix_valid <= 1'b1;
        r_busy      <= 1'b0;
      end
    end
  end

  assign o_mix       = r_mix;
  assign o_mix_valid = r_mix_valid;
  assign o_busy      = r_busy;
  assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_voice_mixer.sv
// tb/tb_voice_mixer.sv - self-checking bench for voice_mixer (HEADROOM_SHIFT 2 and 0 side by side)
module tb_voice_mixer;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        sc = 1'b0;
  logic [55:0] voices = '0;
  logic [3:0]  en = '0;
  logic [7:0]  vol = '0;
  logic [13:0] mix2, mix0;
  logic        valid2, valid0, busy2, busy0, ovr2, ovr0;

  int n_pass = 0;
  int n_total = 0;

  always #62.5 clk = ~clk;

  voice_mixer #(.BITDEPTH(14), .NVOICES(4), .HEADROOM_SHIFT(2)) dut_hs2 (
    .i_clk(clk), .i_resetn(resetn), .i_sample_clock(sc), .i_voices_in(voices),
    .i_voice_enable(en), .i_master_volume(vol), .o_mix(mix2), .o_mix_valid(valid2),
    .o_busy(busy2), .o_overrun(ovr2));

  voice_mixer #(.BITDEPTH(14), .NVOICES(4), .HEADROOM_SHIFT(0)) dut_hs0 (
    .i_clk(clk), .i_resetn(resetn), .i_sample_clock(sc), .i_voices_in(voices),
    .i_voice_enable(en), .i_master_volume(vol), .o_mix(mix0), .o_mix_valid(valid0),
    .o_busy(busy0), .o_overrun(ovr0));

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference: sum of signed voice offsets, scale, floor-divide, clamp, re-offset
  function automatic int model(input logic [55:0] v, input logic [3:0] e,
                               input logic [7:0] g, input int hs);
    longint sum = 0;
    longint p, d, q;
    for (int i = 0; i < 4; i++)
      if (e[i]) sum += longint'(v[i*14 +: 14]) - 8192;
    p = sum * longint'(g);
    d = longint'(1) << (8 + hs);
    q = p / d;
    if ((p % d != 0) && (p < 0)) q = q - 1;
    if (q > 8191) q = 8191;
    if (q < -8192) q = -8192;
    return int'(q + 8192);
  endfunction

  task automatic do_mix(output int lat, output int m2, output int m0,
                        output int busy_mid, output int valid_after);
    lat = -1; m2 = -1; m0 = -1; busy_mid = 0; valid_after = -1;
    @(negedge clk) sc = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k == 3) busy_mid = int'(busy2);
      if (valid2 && valid0) begin
        lat = k; m2 = int'(mix2); m0 = int'(mix0);
        break;
      end
    end
    @(posedge clk); #1;
    valid_after = int'(valid2 | valid0);
    @(negedge clk) sc = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic [55:0] v;
    logic [3:0]  e;
    logic [7:0]  g;
    int          exp2;
    int          exp0;
  } vec_t;

  vec_t vecs[6];
  int lat, m2, m0, bm, va, cnt, lastmix;

  initial begin
    vecs[0] = '{ {4{14'd8192}},  4'hF, 8'd255, 8192,  8192  };
    vecs[1] = '{ {4{14'd16383}}, 4'hF, 8'd255, 16351, 16383 };
    vecs[2] = '{ {4{14'd0}},     4'hF, 8'd255, 32,    0     };
    vecs[3] = '{ {14'd0, 14'd0, 14'd0, 14'd16383}, 4'b0001, 8'd255, 10231, 16351 };
    vecs[4] = '{ {14'd0, 14'd0, 14'd0, 14'd16383}, 4'b0000, 8'd255, 8192,  8192  };
    vecs[5] = '{ {4{14'd16383}}, 4'hF, 8'd0,   8192,  8192  };

    repeat (3) @(posedge clk);
    #1;
    check("reset_mix", int'(mix2), 8192);
    check("reset_valid", int'(valid2), 0);
    check("reset_busy", int'(busy2), 0);
    check("reset_overrun", int'(ovr2), 0);
    @(negedge clk) resetn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      voices = vecs[i].v; en = vecs[i].e; vol = vecs[i].g;
      do_mix(lat, m2, m0, bm, va);
      check($sformatf("vec%0d_latency", i), lat, 7);
      check($sformatf("vec%0d_mix_hs2", i), m2, vecs[i].exp2);
      check($sformatf("vec%0d_mix_hs0", i), m0, vecs[i].exp0);
      if (i == 0) begin
        check("busy_during_mix", bm, 1);
        check("valid_single_pulse", va, 0);
      end
    end

    for (int r = 0; r < 20; r++) begin
      voices = {$urandom(), $urandom()};
      en = 4'($urandom_range(0, 15));
      vol = 8'($urandom_range(0, 255));
      do_mix(lat, m2, m0, bm, va);
      check($sformatf("rand%0d_mix_hs2", r), m2, model(voices, en, vol, 2));
      check($sformatf("rand%0d_mix_hs0", r), m0, model(voices, en, vol, 0));
    end
    check("no_overrun_yet", int'(ovr2 | ovr0), 0);

    // Second edge three clocks after the first, inputs changed after the snapshot
    voices = {4{14'd16383}}; en = 4'hF; vol = 8'd255;
    cnt = 0; lastmix = -1;
    @(negedge clk) sc = 1'b1;
    @(negedge clk) sc = 1'b0;
    @(negedge clk) voices = '0;
    @(negedge clk) sc = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (valid2) begin cnt++; lastmix = int'(mix2); end
    end
    @(negedge clk) sc = 1'b0;
    check("overrun_valid_count", cnt, 1);
    check("overrun_mix_snapshot", lastmix, 16351);
    check("overrun_set", int'(ovr2), 1);
    repeat (10) @(negedge clk);
    check("overrun_sticky", int'(ovr2 & ovr0), 1);
    resetn = 1'b0;
    @(posedge clk); #1;
    check("overrun_cleared", int'(ovr2), 0);
    @(negedge clk) resetn = 1'b1;
    @(negedge clk);

    // Reset while accumulating aborts the mix
    voices = {14'd0, 14'd0, 14'd0, 14'd16383}; en = 4'b0001; vol = 8'd255;
    @(negedge clk) sc = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) begin resetn = 1'b0; sc = 1'b0; end
    @(posedge clk); #1;
    check("abort_valid", int'(valid2), 0);
    check("abort_mix", int'(mix2), 8192);
    check("abort_busy", int'(busy2), 0);
    @(negedge clk) resetn = 1'b1;
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (valid2) cnt++;
    end
    check("abort_no_valid", cnt, 0);
    do_mix(lat, m2, m0, bm, va);
    check("after_abort_latency", lat, 7);
    check("after_abort_mix", m2, 10231);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
